buffer_if_id: RTL and testbench



---
 rtl/buffer_if_id_if.sv | 32 +++
 rtl/buffer_if_id.sv | 84 ++++++++
 tb/tb_buffer_if_id.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/buffer_if_id_if.sv
// Handshake bundle between fetch, the IF/ID buffer and decode.
// The master side is the fetch/decode pair around the buffer, and the slave side is the buffer itself.
interface buffer_if_id_if #(
    parameter int WIDTH = 32
) ();
    // Fetch -> buffer
    logic             in_valid;
    logic [WIDTH-1:0] in_pc4;
    logic [WIDTH-1:0] in_instr;
    logic             in_ready;

    // Buffer -> decode
    logic             out_valid;
    logic [WIDTH-1:0] out_pc4;
    logic [WIDTH-1:0] out_instr;
    logic             out_ready;

    // Redirect and status
    logic             flush;
    logic [1:0]       count;
    logic [15:0]      starve_cnt;

    modport master (
        output in_valid, in_pc4, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_pc4, out_instr, count, starve_cnt
    );

    modport slave (
        input  in_valid, in_pc4, in_instr, out_ready, flush,
        output in_ready, out_valid, out_pc4, out_instr, count, starve_cnt
    );
endinterface

// File: rtl/buffer_if_id.sv
// Two-entry elastic IF/ID buffer. Each entry holds an {pc4, instr} pair, and entries leave in the order they arrived.
// in_ready and out_valid depend only on the registered occupancy, so no combinational path runs from out_ready
// to in_ready. Flush empties the buffer and wins over any push or pop in the same cycle.
// starve_cnt counts cycles in which decode is ready but the buffer has nothing to give, and it saturates.
module buffer_if_id #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP   = '0
) (
    input logic            clk,
    input logic            rst_n,
    buffer_if_id_if.slave  bus
);
    logic [WIDTH-1:0] mem_pc4   [2];
    logic [WIDTH-1:0] mem_instr [2];
    logic             rd;
    logic             wr;
    logic [1:0]       count;
    logic [15:0]      starve_cnt;
    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = bus.in_valid & in_ready  & ~bus.flush;
    assign pop       = out_valid & bus.out_ready & ~bus.flush;

    // Occupancy and pointers: flush drops everything, otherwise push/pop advance their pointers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            rd    <= 1'b0;
            wr    <= 1'b0;
        end else if (bus.flush) begin
            count <= 2'd0;
            rd    <= 1'b0;
            wr    <= 1'b0;
        end else begin
            if (push) wr <= ~wr;
            if (pop)  rd <= ~rd;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage: write the incoming pair into the slot at the write pointer.
    // NOTE: storage has no reset; occupancy alone decides validity, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc4[wr]   <= bus.in_pc4;
            mem_instr[wr] <= bus.in_instr;
        end
    end

    // Starvation counter: decode ready with nothing valid, saturating, untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 16'd0;
        end else if (!out_valid && bus.out_ready && (starve_cnt != 16'hFFFF)) begin
            starve_cnt <= starve_cnt + 16'd1;
        end
    end

    // Head presentation: show the entry at the read pointer, or zero/NOP when empty.
    // NOTE: defaults are assigned first so no path leaves an output unassigned (no latch).
    always_comb begin
        bus.out_pc4   = '0;
        bus.out_instr = NOP;
        if (out_valid) begin
            bus.out_pc4   = mem_pc4[rd];
            bus.out_instr = mem_instr[rd];
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.count      = count;
    assign bus.starve_cnt = starve_cnt;
endmodule

// File: tb/tb_buffer_if_id.sv
// Directed bench for the IF/ID buffer. It covers reset, streaming, backpressure, simultaneous push/pop,
// flush and starvation saturation.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_buffer_if_id;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    buffer_if_id_if #(.WIDTH(WIDTH)) bus ();

    buffer_if_id #(.WIDTH(WIDTH), .NOP(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc4, input logic [31:0] instr, input logic ordy,
                         input logic fl);
        bus.in_valid  = v;
        bus.in_pc4    = pc4;
        bus.in_instr  = instr;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic chk_head(input string tag, input logic [1:0] cnt, input logic [31:0] pc4,
                            input logic [31:0] instr);
        chk({tag, "_count"}, {30'd0, bus.count}, {30'd0, cnt});
        chk({tag, "_pc4"},   bus.out_pc4, pc4);
        chk({tag, "_instr"}, bus.out_instr, instr);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("rst_count",  {30'd0, bus.count}, 32'd0);
        chk("rst_valid",  {31'd0, bus.out_valid}, 32'd0);
        chk("rst_instr",  bus.out_instr, 32'h0);
        chk("rst_pc4",    bus.out_pc4, 32'h0);
        chk("rst_ready",  {31'd0, bus.in_ready}, 32'd1);
        chk("rst_starve", {16'd0, bus.starve_cnt}, 32'd0);
        #11 rst_n = 1'b1;

        // Streaming with decode always ready: each pair appears one edge later and count stays at 1.
        drive(1'b1, 32'd4, 32'h2008_0005, 1'b1, 1'b0);
        tick();
        chk_head("s1", 2'd1, 32'd4, 32'h2008_0005);
        chk("s1_valid", {31'd0, bus.out_valid}, 32'd1);
        drive(1'b1, 32'd8, 32'h2129_0001, 1'b1, 1'b0);
        tick();
        chk_head("s2", 2'd1, 32'd8, 32'h2129_0001);
        chk("s2_ready", {31'd0, bus.in_ready}, 32'd1);
        drive(1'b1, 32'd12, 32'h0109_5020, 1'b1, 1'b0);
        tick();
        chk_head("s3", 2'd1, 32'd12, 32'h0109_5020);
        chk("s3_ready", {31'd0, bus.in_ready}, 32'd1);
        drive(1'b0, 32'd0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_head("s4", 2'd0, 32'h0, 32'h0);
        chk("s4_valid", {31'd0, bus.out_valid}, 32'd0);
        // Only the first streaming edge saw an empty buffer while decode was ready.
        chk("s4_starve", {16'd0, bus.starve_cnt}, 32'd1);

        // Backpressure: fill the buffer, and the third word must wait.
        drive(1'b1, 32'h100, 32'hAAAA_0001, 1'b0, 1'b0);
        tick();
        chk_head("b1", 2'd1, 32'h100, 32'hAAAA_0001);
        chk("b1_ready", {31'd0, bus.in_ready}, 32'd1);
        drive(1'b1, 32'h104, 32'hAAAA_0002, 1'b0, 1'b0);
        tick();
        chk_head("b2", 2'd2, 32'h100, 32'hAAAA_0001);
        chk("b2_ready", {31'd0, bus.in_ready}, 32'd0);
        drive(1'b1, 32'h108, 32'hAAAA_0003, 1'b0, 1'b0);
        tick();
        chk_head("b3_stable", 2'd2, 32'h100, 32'hAAAA_0001);
        chk("b3_ready", {31'd0, bus.in_ready}, 32'd0);
        // Full: decode pops, and the held input is ignored on this edge.
        drive(1'b1, 32'h108, 32'hAAAA_0003, 1'b1, 1'b0);
        tick();
        chk_head("b4", 2'd1, 32'h104, 32'hAAAA_0002);
        chk("b4_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk_head("b5", 2'd1, 32'h108, 32'hAAAA_0003);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_head("b6", 2'd0, 32'h0, 32'h0);

        // Simultaneous push and pop at count 1.
        drive(1'b1, 32'h200, 32'h11, 1'b0, 1'b0);
        tick();
        chk_head("pp1", 2'd1, 32'h200, 32'h11);
        drive(1'b1, 32'h204, 32'h22, 1'b1, 1'b0);
        tick();
        chk_head("pp2", 2'd1, 32'h204, 32'h22);

        // Flush at count 2 with a push and a pop requested at the same time.
        drive(1'b1, 32'h208, 32'h33, 1'b0, 1'b0);
        tick();
        chk_head("f0", 2'd2, 32'h204, 32'h22);
        drive(1'b1, 32'h20C, 32'h44, 1'b1, 1'b1);
        tick();
        chk_head("f1", 2'd0, 32'h0, 32'h0);
        chk("f1_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("f1_ready", {31'd0, bus.in_ready}, 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        chk_head("f2", 2'd0, 32'h0, 32'h0);
        // Flush does not clear the starvation counter.
        chk("f2_starve", {16'd0, bus.starve_cnt}, 32'd1);

        // Asynchronous reset mid-stream with the buffer full.
        drive(1'b1, 32'h300, 32'h55, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h304, 32'h66, 1'b0, 1'b0);
        tick();
        chk("ar_full", {30'd0, bus.count}, 32'd2);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_count",  {30'd0, bus.count}, 32'd0);
        chk("ar_valid",  {31'd0, bus.out_valid}, 32'd0);
        chk("ar_instr",  bus.out_instr, 32'h0);
        chk("ar_ready",  {31'd0, bus.in_ready}, 32'd1);
        chk("ar_starve", {16'd0, bus.starve_cnt}, 32'd0);
        #2 rst_n = 1'b1;
        drive(1'b1, 32'h400, 32'h77, 1'b0, 1'b0);
        tick();
        chk_head("ar_push", 2'd1, 32'h400, 32'h77);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_head("ar_pop", 2'd0, 32'h0, 32'h0);
        chk("ar_pop_starve", {16'd0, bus.starve_cnt}, 32'd0);

        // Starvation: empty buffer with decode ready, then walk up to saturation.
        repeat (5) tick();
        chk("st5", {16'd0, bus.starve_cnt}, 32'd5);
        repeat (65534 - 5) tick();
        chk("st_fffe", {16'd0, bus.starve_cnt}, 32'h0000_FFFE);
        repeat (3) tick();
        chk("st_sat", {16'd0, bus.starve_cnt}, 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
